display_mux: RTL and testbench
==============================

# display_mux

Parametrised time-multiplexing driver for a bank of common-anode seven-segment digits sharing one segment bus. It cycles a one-hot anode enable across `NUM_DIGITS` digits at a programmable dwell rate. It inserts an all-off blanking interval between digits to suppress ghosting, skips digits masked off, and presents the selected digit's nibble to the downstream segment decoder. It replaces the fixed two-digit select-to-anode mapping in the display path.

## Interface
Parameters:
- `NUM_DIGITS`, default 2: number of digits; legal range 2..8.
- `DWELL_CYCLES`, default 50000: clock cycles a digit's anode is active per visit; must be ≥1.
- `BLANK_CYCLES`, default 500: all-anodes-off cycles between digits; must be ≥1.
- `ANODE_ACTIVE_LOW`, default 0: 0 means the active anode level is 1; 1 means the active level is 0.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: global display enable.
- `digit_en`, input, NUM_DIGITS: per-digit enable mask; bit i enables digit i.
- `digits`, input, 4*NUM_DIGITS: packed nibbles; digit i is `digits[4i+3:4i]`.
- `anode_power`, output, NUM_DIGITS: anode drive; at most one bit at the active level.
- `sel`, output, max(1, $clog2(NUM_DIGITS)): index of the current or last-shown digit.
- `nibble`, output, 4: value of digit `sel`, captured on entry to SHOW.
- `blank`, output, 1: high when all anodes are inactive.
- `frame_tick`, output, 1: one-cycle pulse when the scan wraps.

## Operation
- Two-state FSM, BLANK and SHOW, with one shared down-counter `cnt` sized for max(DWELL_CYCLES, BLANK_CYCLES).
- BLANK: all anodes inactive and `blank`=1.
  - Runs for BLANK_CYCLES cycles.
  - On the last cycle, it samples `digit_en` and selects the next digit: the lowest enabled index strictly greater than `sel`, otherwise the lowest enabled index overall (wrap).
  - If `digit_en` is all zero, it stays in BLANK, reloads `cnt`, and holds `sel`.
- SHOW: `anode_power[sel]` is at the active level and all other bits are inactive; `blank`=0.
  - Runs for DWELL_CYCLES cycles, then returns to BLANK.
- `nibble` is loaded from `digits` for the new `sel` on the BLANK→SHOW transition and held for the whole SHOW. Mid-dwell changes to `digits` have no effect.
- Changes to `digit_en` during SHOW do not shorten the current dwell. The mask is sampled only at selection time.
- `frame_tick`:
  - Pulses for 1 cycle, coincident with the first SHOW cycle, whenever the new index is ≤ the previous index (wrap).
  - With a single enabled digit, it pulses on every visit.
  - It does not pulse on the first selection after reset.
- `en`=0:
  - The next edge forces BLANK with `cnt` reloaded and `sel`, `nibble` held.
  - While `en`=0, the FSM stays in BLANK.
  - When `en` returns to 1, a full BLANK interval runs, then the next digit after `sel` is selected.
- All outputs are registered.
- The inactive anode level is 0 when ANODE_ACTIVE_LOW=0 and 1 when ANODE_ACTIVE_LOW=1.

## Timing
- Reset (`reset`=0, asynchronous, no clock needed):
  - State BLANK, `cnt`=BLANK_CYCLES-1, `sel`=0.
  - `anode_power` all inactive, `nibble`=0, `blank`=1, `frame_tick`=0.
  - A first-selection flag is set.
- Reset release: count the first rising edge with `reset`=1 as edge 1.
  - Anodes stay inactive for BLANK_CYCLES cycles.
  - The lowest enabled digit becomes active on edge BLANK_CYCLES.
- Steady-state period per enabled digit: DWELL_CYCLES + BLANK_CYCLES cycles.
- Anode transitions are never overlapping. Every change of active digit passes through at least BLANK_CYCLES all-off cycles.
- Reset asserted mid-SHOW: anodes go inactive immediately (asynchronously), and the reset sequence above restarts on release.

## Test plan
- Basic scan. NUM_DIGITS=2, DWELL=4, BLANK=2, `digit_en`=2'b11, `digits`=8'hA5, release reset.
  - 2 cycles of `anode_power`=00.
  - 4 cycles of 01 with `nibble`=5.
  - 2 cycles of 00.
  - 4 cycles of 10 with `nibble`=A.
  - 2 cycles of 00.
  - Then 01 with `frame_tick`=1 for exactly 1 cycle.
- Mask skip. NUM_DIGITS=4, `digit_en`=4'b1010.
  - `sel` sequence is 1, 3, 1, 3.
  - `frame_tick` pulses on each 3→1.
  - Digits 0 and 2 never go active.
- Empty mask. `digit_en`=0.
  - `anode_power` stays all inactive and `blank`=1 indefinitely.
  - Set `digit_en`=4'b0100: digit 2 goes active within ≤2·BLANK_CYCLES cycles.
- Data stability. Change `digits` mid-dwell: `nibble` is unchanged until the next SHOW entry, then reflects the new value.
- Enable gating. Drop `en` mid-SHOW of digit 0.
  - All anodes go inactive on the next edge; `sel`=0 is held.
  - Raise `en`: after BLANK_CYCLES, digit 1 goes active.
- Async reset and polarity. Assert `reset` between clock edges during SHOW.
  - Outputs reach reset values before the next edge.
  - With ANODE_ACTIVE_LOW=1, the idle `anode_power`=all-ones and the active digit reads 0.

Source files
------------

// File: rtl/display_mux.sv
// Time-multiplexed anode driver for common-anode seven-segment digits.
// Alternates BLANK (all off) and SHOW (one digit on) using one shared down-counter.
module display_mux #(
  parameter int NUM_DIGITS       = 2,
  parameter int DWELL_CYCLES     = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter int ANODE_ACTIVE_LOW = 0,
  localparam int SW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES,
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   anode_power,
  output logic [SW-1:0]           sel,
  output logic [3:0]              nibble,
  output logic                    blank,
  output logic                    frame_tick
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam logic [CW-1:0]         BLANK_LOAD = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]         DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                         : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [3:0]              nib_q, nib_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    blank_q, blank_d;
  logic                    tick_q, tick_d;
  logic                    first_q, first_d;

  logic                    hit_any, hit_above;
  logic [SW-1:0]           idx_low, idx_above, nxt;

  // Lowest enabled index overall and lowest enabled index above sel.
  always_comb begin
    hit_any   = 1'b0;
    hit_above = 1'b0;
    idx_low   = '0;
    idx_above = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_en[i]) begin
        if (!hit_any) begin
          hit_any = 1'b1;
          idx_low = SW'(i);
        end
        if (!hit_above && (i > 32'(sel_q))) begin
          hit_above = 1'b1;
          idx_above = SW'(i);
        end
      end
    end
    nxt = (first_q || !hit_above) ? idx_low : idx_above;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    nib_d   = nib_q;
    an_d    = an_q;
    blank_d = blank_q;
    tick_d  = 1'b0;
    first_d = first_q;
    if (!en) begin
      state_d = ST_BLANK;
      cnt_d   = BLANK_LOAD;
      an_d    = AN_OFF;
      blank_d = 1'b1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!hit_any) begin
            cnt_d = BLANK_LOAD;
          end else begin
            state_d = ST_SHOW;
            cnt_d   = DWELL_LOAD;
            sel_d   = nxt;
            nib_d   = digits[{nxt, 2'b00} +: 4];
            an_d    = AN_OFF ^ (AN_ONE << nxt);
            blank_d = 1'b0;
            // No index above sel means the scan wrapped (or a lone digit repeated).
            tick_d  = !first_q && !hit_above;
            first_d = 1'b0;
          end
        end
        ST_SHOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            an_d    = AN_OFF;
            blank_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
          an_d    = AN_OFF;
          blank_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= BLANK_LOAD;
      sel_q   <= '0;
      nib_q   <= '0;
      an_q    <= AN_OFF;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      nib_q   <= nib_d;
      an_q    <= an_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
      first_q <= first_d;
    end
  end

  assign anode_power = an_q;
  assign sel         = sel_q;
  assign nibble      = nib_q;
  assign blank       = blank_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux: fixed 2-digit scan table plus a
// 4-digit active-low instance checked against a cycle-level reference model.
module tb_display_mux;

  localparam int TD = 5;
  localparam int TB = 3;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  // 4-digit active-low instance
  logic        rst_n, en;
  logic [3:0]  mask;
  logic [15:0] digits;
  logic [3:0]  anode_power;
  logic [1:0]  sel;
  logic [3:0]  nibble;
  logic        blank, frame_tick;

  // 2-digit active-high instance
  logic        rst2_n, en2;
  logic [1:0]  den2;
  logic [7:0]  dig2;
  logic [1:0]  an2;
  logic        sel2;
  logic [3:0]  nib2;
  logic        blank2, tick2;

  display_mux #(.NUM_DIGITS(4), .DWELL_CYCLES(TD), .BLANK_CYCLES(TB), .ANODE_ACTIVE_LOW(1)) u4 (
    .clk(clk), .reset(rst_n), .en(en), .digit_en(mask), .digits(digits),
    .anode_power(anode_power), .sel(sel), .nibble(nibble), .blank(blank), .frame_tick(frame_tick)
  );

  display_mux #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(0)) u2 (
    .clk(clk), .reset(rst2_n), .en(en2), .digit_en(den2), .digits(dig2),
    .anode_power(an2), .sel(sel2), .nibble(nib2), .blank(blank2), .frame_tick(tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase (showing or not), cycles left in phase, shown digit.
  logic       m_show, m_first, m_tick;
  int         m_left;
  logic [1:0] m_sel;
  logic [3:0] m_nib;

  wire [11:0] obs_vec = {anode_power, sel, nibble, blank, frame_tick};

  function automatic logic [1:0] next_after(input logic [1:0] s, input logic [3:0] m);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(s) + k) % 4;
      if (m[idx]) return 2'(idx);
    end
    return s;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] a;
    a = 4'hF;
    if (m_show) a[m_sel] = 1'b0;
    return {a, m_sel, m_nib, !m_show, m_tick};
  endfunction

  task automatic model_reset();
    m_show = 1'b0; m_first = 1'b1; m_tick = 1'b0;
    m_left = TB;   m_sel = 2'd0;   m_nib = 4'h0;
  endtask

  task automatic model_edge();
    logic [1:0] nx;
    m_tick = 1'b0;
    if (!en) begin
      m_show = 1'b0; m_left = TB;
    end else if (m_left > 1) begin
      m_left--;
    end else if (m_show) begin
      m_show = 1'b0; m_left = TB;
    end else if (mask == 4'h0) begin
      m_left = TB;
    end else begin
      nx      = m_first ? next_after(2'd3, mask) : next_after(m_sel, mask);
      m_tick  = !m_first && (nx <= m_sel);
      m_sel   = nx;
      m_nib   = digits[4*nx +: 4];
      m_first = 1'b0;
      m_show  = 1'b1;
      m_left  = TD;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (!rst_n) model_reset(); else model_edge();
  endtask

  task automatic test_basic_scan();
    logic [1:0] ea;
    logic [3:0] en_;
    logic       es, et;
    rst2_n = 1'b1;
    checks++;
    if (an2 !== 2'b00 || blank2 !== 1'b1) begin
      failures++; $display("FAIL basic_release an=%b blank=%b exp an=00 blank=1", an2, blank2);
    end
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      ea  = ((k >= 2 && k <= 5) || k >= 14) ? 2'b01 : (k >= 8 && k <= 11) ? 2'b10 : 2'b00;
      en_ = (k == 1) ? 4'h0 : (k >= 8 && k <= 13) ? 4'hA : 4'h5;
      es  = (k >= 8 && k <= 13);
      et  = (k == 14);
      checks++;
      if (an2 !== ea || nib2 !== en_ || sel2 !== es || tick2 !== et || blank2 !== (ea == 2'b00)) begin
        failures++;
        $display("FAIL basic_scan edge=%0d an=%b nib=%h sel=%b tick=%b blank=%b exp an=%b nib=%h sel=%b tick=%b",
                 k, an2, nib2, sel2, tick2, blank2, ea, en_, es, et);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== {4'hF, 2'd0, 4'h0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_state obs=%h exp=%h", obs_vec, {4'hF, 2'd0, 4'h0, 1'b1, 1'b0});
    end
    step();
    mask   = 4'b1111;
    digits = 16'($urandom);
    rst_n  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL reset_release cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_mask_skip();
    int ticks = 0;
    mask = 4'b1010;
    for (int i = 0; i < 70; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL mask_skip cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (i > TD && (anode_power[0] !== 1'b1 || anode_power[2] !== 1'b1)) begin
        failures++; $display("FAIL mask_skip_masked cyc=%0d anode=%b", i, anode_power);
      end
      if (frame_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks < 3) begin
      failures++; $display("FAIL mask_skip_ticks got=%0d need>=3", ticks);
    end
  endtask

  task automatic test_empty_mask();
    bit seen = 0;
    mask = 4'b0000;
    for (int i = 0; i < TD + TB + 20; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL empty_mask cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (i > TD && (anode_power !== 4'hF || blank !== 1'b1)) begin
        failures++; $display("FAIL empty_mask_idle cyc=%0d anode=%b blank=%b", i, anode_power, blank);
      end
    end
    mask = 4'b0100;
    for (int i = 0; i < 2*TB && !seen; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL empty_mask_wake cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (anode_power === 4'b1011) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL empty_mask_timeout anode=%b exp=1011", anode_power);
    end
  endtask

  task automatic test_data_stability();
    logic [3:0] held;
    bit         found;
    mask = 4'b1111;
    for (int pass = 0; pass < 2; pass++) begin
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        found = (blank === 1'b0 && frame_tick !== 1'bx && (m_left == TD));
      end
      checks++;
      if (!found || nibble !== digits[4*sel +: 4]) begin
        failures++; $display("FAIL data_entry found=%0d nibble=%h exp=%h", found, nibble, digits[4*sel +: 4]);
      end
      held = nibble;
      for (int i = 0; i < TD - 1; i++) begin
        digits = 16'($urandom);
        step();
        checks++;
        if (nibble !== held || obs_vec !== exp_vec()) begin
          failures++; $display("FAIL data_hold cyc=%0d nibble=%h exp=%h", i, nibble, held);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    bit found = 0;
    mask = 4'b1111;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = (anode_power === 4'b1110);
    end
    step();
    en = 1'b0;
    step();
    checks++;
    if (!found || anode_power !== 4'hF || sel !== 2'd0 || blank !== 1'b1) begin
      failures++; $display("FAIL en_drop found=%0d anode=%b sel=%0d blank=%b exp anode=1111 sel=0", found, anode_power, sel, blank);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL en_low cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
    en = 1'b1;
    for (int i = 0; i < TB - 1; i++) begin
      step();
      checks++;
      if (anode_power !== 4'hF) begin
        failures++; $display("FAIL en_reblank cyc=%0d anode=%b exp=1111", i, anode_power);
      end
    end
    step();
    checks++;
    if (anode_power !== 4'b1101 || sel !== 2'd1 || frame_tick !== 1'b0) begin
      failures++; $display("FAIL en_resume anode=%b sel=%0d tick=%b exp anode=1101 sel=1 tick=0", anode_power, sel, frame_tick);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (blank === 1'b0);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (!found || obs_vec !== {4'hF, 2'd0, 4'h0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL async_reset found=%0d obs=%h exp=%h", found, obs_vec, {4'hF, 2'd0, 4'h0, 1'b1, 1'b0});
    end
    model_reset();
    step();
    mask  = 4'b0110;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL async_restart cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en     = ($urandom_range(0, 19) != 0);
      digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mask = 4'h0; digits = 16'h0;
    rst2_n = 1'b0; en2 = 1'b1; den2 = 2'b11; dig2 = 8'hA5;
    model_reset();
    @(posedge clk); #1;
    test_basic_scan();
    test_reset();
    test_mask_skip();
    test_empty_mask();
    test_data_stability();
    test_enable_gating();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
